cache_lookup_ctrl: RTL and testbench



---
 rtl/cache_lookup_ctrl_pkg.sv | 26 ++
 rtl/cache_tag_array.sv | 67 ++++++
 rtl/cache_lookup_ctrl.sv | 176 +++++++++++++++++
 tb/tb_cache_lookup_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_lookup_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// cache_ctrl_pkg : shared types for the cache lookup controller
// Revision 1.0
// ============================================================================
package cache_ctrl_pkg;
   localparam int WAY_BITS     = 4;
   localparam int MAX_TAG_BITS = 32;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOOKUP    = 3'd1,
      ST_HIT       = 3'd2,
      ST_MISS_WAIT = 3'd3,
      ST_FILL      = 3'd4
   } state_e;

   typedef struct packed {
      logic                    hit;
      logic [WAY_BITS-1:0]     way;
      logic                    evict;
      logic [MAX_TAG_BITS-1:0] evict_tag;
      logic                    error;
   } resp_t;
endpackage
`default_nettype wire

// File: rtl/cache_tag_array.sv
`default_nettype none
// ============================================================================
// cache_tag_array : per-set tag/valid store with parallel compare
// Revision 1.0
// ============================================================================
module cache_tag_array
   import cache_ctrl_pkg::*;
#(
   parameter int NUM_WAYS        = 16,
   parameter int NUM_SETS        = 128,
   parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
   parameter int TAG_BITS        = 20
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [SET_INDEX_WIDTH-1:0] cmp_set,
   input  logic [TAG_BITS-1:0]        cmp_tag,
   output logic                       cmp_hit,
   output logic [WAY_BITS-1:0]        cmp_way,
   input  logic [SET_INDEX_WIDTH-1:0] rd_set,
   input  logic [WAY_BITS-1:0]        rd_way,
   output logic                       rd_valid,
   output logic [TAG_BITS-1:0]        rd_tag,
   input  logic                       wr_en,
   input  logic [SET_INDEX_WIDTH-1:0] wr_set,
   input  logic [WAY_BITS-1:0]        wr_way,
   input  logic [TAG_BITS-1:0]        wr_tag
);
   logic [TAG_BITS-1:0] tag_mem [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
   logic [NUM_WAYS-1:0] match;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
         end
      end else if (wr_en) begin
         valid_q[wr_set][wr_way] <= 1'b1;
      end
   end

   // Tag storage is deliberately left unreset; valid bits gate every use.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_set][wr_way] <= wr_tag;
      end
   end

   for (genvar w = 0; w < NUM_WAYS; w++) begin : g_cmp
      assign match[w] = valid_q[cmp_set][w] && (tag_mem[cmp_set][w] == cmp_tag);
   end

   always_comb begin
      cmp_hit = |match;
      cmp_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (match[w]) begin
            cmp_way = WAY_BITS'(w);
         end
      end
   end

   assign rd_valid = valid_q[rd_set][rd_way];
   assign rd_tag   = tag_mem[rd_set][rd_way];
endmodule
`default_nettype wire

// File: rtl/cache_lookup_ctrl.sv
`default_nettype none
// ============================================================================
// cache_lookup_ctrl : tag lookup front end driving the DRRIP policy block
// Revision 1.0
// ============================================================================
module cache_lookup_ctrl
   import cache_ctrl_pkg::*;
#(
   parameter int NUM_WAYS        = 16,
   parameter int NUM_SETS        = 128,
   parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
   parameter int TAG_BITS        = 20,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [SET_INDEX_WIDTH-1:0] req_set,
   input  logic [TAG_BITS-1:0]        req_tag,
   output logic                       resp_valid,
   output logic                       resp_hit,
   output logic [3:0]                 resp_way,
   output logic                       resp_evict,
   output logic [TAG_BITS-1:0]        resp_evict_tag,
   output logic                       resp_error,
   output logic                       pol_valid,
   output logic                       pol_hit,
   output logic                       pol_miss,
   output logic [SET_INDEX_WIDTH-1:0] pol_set_index,
   output logic [3:0]                 pol_access_way,
   input  logic [3:0]                 pol_victim_way,
   input  logic                       pol_victim_ready
);
   localparam int WDOG_BITS = $clog2(TIMEOUT_CYCLES) + 1;

   state_e                     state_q, state_d;
   logic [SET_INDEX_WIDTH-1:0] set_q, set_d;
   logic [TAG_BITS-1:0]        tag_q, tag_d;
   logic [WDOG_BITS-1:0]       wdog_q, wdog_d;
   resp_t                      resp_q, resp_d;
   logic                       resp_valid_q, resp_valid_d;
   logic                       req_ready_q, req_ready_d;
   logic                       pol_valid_q, pol_valid_d;
   logic                       pol_hit_q, pol_hit_d;
   logic                       pol_miss_q, pol_miss_d;
   logic [SET_INDEX_WIDTH-1:0] pol_set_q, pol_set_d;
   logic [WAY_BITS-1:0]        pol_way_q, pol_way_d;

   logic                       cmp_hit;
   logic [WAY_BITS-1:0]        cmp_way;
   logic                       rd_valid;
   logic [TAG_BITS-1:0]        rd_tag;
   logic                       timeout;
   logic                       unused_tag_bits;

   cache_tag_array #(
      .NUM_WAYS        (NUM_WAYS),
      .NUM_SETS        (NUM_SETS),
      .SET_INDEX_WIDTH (SET_INDEX_WIDTH),
      .TAG_BITS        (TAG_BITS)
   ) u_tags (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmp_set  (set_q),
      .cmp_tag  (tag_q),
      .cmp_hit  (cmp_hit),
      .cmp_way  (cmp_way),
      .rd_set   (set_q),
      .rd_way   (pol_victim_way),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .wr_en    ((state_q == ST_FILL) && !resp_q.error),
      .wr_set   (set_q),
      .wr_way   (resp_q.way),
      .wr_tag   (tag_q)
   );

   assign timeout = (wdog_q == WDOG_BITS'(TIMEOUT_CYCLES - 1));

   // Victim data is sampled as the victim arrives so the response is registered for FILL.
   always_comb begin
      state_d = state_q;
      set_d   = set_q;
      tag_d   = tag_q;
      wdog_d  = '0;
      resp_d  = '0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = ST_LOOKUP;
               set_d   = req_set;
               tag_d   = req_tag;
            end
         end
         ST_LOOKUP: begin
            if (cmp_hit) begin
               state_d    = ST_HIT;
               resp_d.hit = 1'b1;
               resp_d.way = cmp_way;
            end else begin
               state_d = ST_MISS_WAIT;
            end
         end
         ST_HIT:  state_d = ST_IDLE;
         ST_MISS_WAIT: begin
            wdog_d = wdog_q + WDOG_BITS'(1);
            if (pol_victim_ready) begin
               state_d                         = ST_FILL;
               resp_d.way                      = pol_victim_way;
               resp_d.evict                    = rd_valid;
               resp_d.evict_tag[TAG_BITS-1:0]  = rd_tag;
            end else if (timeout) begin
               state_d      = ST_FILL;
               resp_d.error = 1'b1;
            end
         end
         ST_FILL: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      resp_valid_d = (state_d == ST_HIT) || (state_d == ST_FILL);
      req_ready_d  = (state_d == ST_IDLE);
      pol_hit_d    = (state_d == ST_HIT);
      pol_miss_d   = (state_d == ST_MISS_WAIT);
      pol_valid_d  = pol_hit_d || pol_miss_d;
      pol_set_d    = pol_valid_d ? set_d : '0;
      pol_way_d    = pol_hit_d ? cmp_way : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         set_q        <= '0;
         tag_q        <= '0;
         wdog_q       <= '0;
         resp_q       <= '0;
         resp_valid_q <= 1'b0;
         req_ready_q  <= 1'b1;
         pol_valid_q  <= 1'b0;
         pol_hit_q    <= 1'b0;
         pol_miss_q   <= 1'b0;
         pol_set_q    <= '0;
         pol_way_q    <= '0;
      end else begin
         state_q      <= state_d;
         set_q        <= set_d;
         tag_q        <= tag_d;
         wdog_q       <= wdog_d;
         resp_q       <= resp_d;
         resp_valid_q <= resp_valid_d;
         req_ready_q  <= req_ready_d;
         pol_valid_q  <= pol_valid_d;
         pol_hit_q    <= pol_hit_d;
         pol_miss_q   <= pol_miss_d;
         pol_set_q    <= pol_set_d;
         pol_way_q    <= pol_way_d;
      end
   end

   assign req_ready       = req_ready_q;
   assign resp_valid      = resp_valid_q;
   assign resp_hit        = resp_q.hit;
   assign resp_way        = resp_q.way;
   assign resp_evict      = resp_q.evict;
   assign resp_evict_tag  = resp_q.evict_tag[TAG_BITS-1:0];
   assign resp_error      = resp_q.error;
   assign unused_tag_bits = ^resp_q.evict_tag;

   // Dropped in the victim cycle so the policy never starts a second search.
   assign pol_valid       = pol_valid_q && !(pol_miss_q && pol_victim_ready);
   assign pol_hit         = pol_hit_q;
   assign pol_miss        = pol_miss_q;
   assign pol_set_index   = pol_set_q;
   assign pol_access_way  = pol_way_q;
endmodule
`default_nettype wire

// File: tb/tb_cache_lookup_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cache_lookup_ctrl : vector table + scoreboard bench with a policy model
// Revision 1.0
// ============================================================================
module tb_cache_lookup_ctrl;
   localparam int TO  = 64;
   localparam int DLY = 3;

   logic        clk, rst_n;
   logic        req_valid, req_ready;
   logic [6:0]  req_set;
   logic [19:0] req_tag;
   logic        resp_valid, resp_hit, resp_evict, resp_error;
   logic [3:0]  resp_way;
   logic [19:0] resp_evict_tag;
   logic        pol_valid, pol_hit, pol_miss;
   logic [6:0]  pol_set_index;
   logic [3:0]  pol_access_way;
   logic [3:0]  pol_victim_way;
   logic        pol_victim_ready;

   cache_lookup_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_set          (req_set),
      .req_tag          (req_tag),
      .resp_valid       (resp_valid),
      .resp_hit         (resp_hit),
      .resp_way         (resp_way),
      .resp_evict       (resp_evict),
      .resp_evict_tag   (resp_evict_tag),
      .resp_error       (resp_error),
      .pol_valid        (pol_valid),
      .pol_hit          (pol_hit),
      .pol_miss         (pol_miss),
      .pol_set_index    (pol_set_index),
      .pol_access_way   (pol_access_way),
      .pol_victim_way   (pol_victim_way),
      .pol_victim_ready (pol_victim_ready)
   );

   typedef struct {
      logic [6:0]  set;
      logic [19:0] tag;
      logic        vic_ok;
      logic [3:0]  vic;
      logic        hit;
      logic [3:0]  way;
      logic        evict;
      logic [19:0] evict_tag;
      logic        error;
   } vec_t;

   typedef struct {
      logic        hit;
      logic [3:0]  way;
      logic        evict;
      logic [19:0] evict_tag;
      logic        error;
      int          cyc;
   } exp_t;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         pol_hit_cnt = 0;
   exp_t       sb[$];
   logic [3:0] pol_ways[$];
   vec_t       vecs[$];
   logic [6:0] exp_pol_set = '0;
   logic [3:0] exp_pol_way = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [6:0] s, input logic [19:0] t, input logic ok,
                               input logic [3:0] vic, input logic h, input logic [3:0] w,
                               input logic ev, input logic [19:0] et, input logic er);
      vec_t v;
      v.set = s; v.tag = t; v.vic_ok = ok; v.vic = vic; v.hit = h;
      v.way = w; v.evict = ev; v.evict_tag = et; v.error = er;
      return v;
   endfunction

   // Policy model: answers a miss search DLY cycles after pol_valid rises.
   initial begin
      logic [3:0] w;
      pol_victim_ready = 1'b0;
      pol_victim_way   = '0;
      forever begin
         @(negedge clk);
         if (rst_n && pol_valid && pol_miss && pol_ways.size() != 0) begin
            w = pol_ways.pop_front();
            for (int k = 1; k < DLY; k++) begin
               @(negedge clk);
               chk("pol_valid_held", {30'd0, pol_valid, pol_miss}, 32'd3);
            end
            @(negedge clk);
            pol_victim_ready = 1'b1;
            pol_victim_way   = w;
            #1 chk("pol_valid_victim_cycle", {31'd0, pol_valid}, 32'd0);
            @(negedge clk);
            pol_victim_ready = 1'b0;
            pol_victim_way   = '0;
         end
      end
   end

   // Output monitor and scoreboard consumer.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pol_hit) begin
            pol_hit_cnt++;
            chk("pol_hit_valid", {31'd0, pol_valid}, 32'd1);
            chk("pol_hit_set", {25'd0, pol_set_index}, {25'd0, exp_pol_set});
            chk("pol_hit_way", {28'd0, pol_access_way}, {28'd0, exp_pol_way});
         end else if (pol_miss) begin
            chk("pol_miss_set", {25'd0, pol_set_index}, {25'd0, exp_pol_set});
         end else begin
            chk("pol_idle_zero", {20'd0, pol_valid, pol_set_index, pol_access_way}, 32'd0);
         end
         if (pol_hit || pol_miss || resp_valid)
            chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
         if (resp_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected actual=1 required=0");
            end else begin
               e = sb.pop_front();
               chk("resp_hit", {31'd0, resp_hit}, {31'd0, e.hit});
               chk("resp_way", {28'd0, resp_way}, {28'd0, e.way});
               chk("resp_evict", {31'd0, resp_evict}, {31'd0, e.evict});
               chk("resp_error", {31'd0, resp_error}, {31'd0, e.error});
               chk("resp_cycle", cyc, e.cyc);
               if (e.evict) chk("resp_evict_tag", {12'd0, resp_evict_tag}, {12'd0, e.evict_tag});
               if (!e.hit) chk("pol_valid_at_fill", {31'd0, pol_valid}, 32'd0);
            end
         end else begin
            chk("resp_idle_zero", {5'd0, resp_hit, resp_way, resp_evict, resp_evict_tag, resp_error}, 32'd0);
         end
      end
   end

   task automatic issue(input logic [6:0] s, input logic [19:0] t, output int acc);
      int k;
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_set   = s;
      req_tag   = t;
      acc       = cyc;
      @(posedge clk);
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
      chk("resp_drained", sb.size(), 32'd0);
      sb.delete();
      @(negedge clk);
   endtask

   function automatic exp_t mk_exp(input vec_t v, input int acc);
      exp_t e;
      e.hit = v.hit; e.way = v.way; e.evict = v.evict;
      e.evict_tag = v.evict_tag; e.error = v.error;
      e.cyc = acc + (v.hit ? 2 : (v.error ? 2 + TO : 3 + DLY));
      return e;
   endfunction

   task automatic run_vec(input vec_t v);
      int acc;
      pol_ways.delete();
      if (v.vic_ok) pol_ways.push_back(v.vic);
      exp_pol_set = v.set;
      exp_pol_way = v.way;
      pol_hit_cnt = 0;
      issue(v.set, v.tag, acc);
      sb.push_back(mk_exp(v, acc));
      @(negedge clk);
      req_valid = 1'b0;
      chk("req_ready_lookup", {31'd0, req_ready}, 32'd0);
      wait_drain();
      chk("pol_hit_count", pol_hit_cnt, v.hit ? 32'd1 : 32'd0);
   endtask

   initial begin
      int acc, acc2, k, gap;
      bit seen_hi;
      req_valid = 1'b0;
      req_set   = '0;
      req_tag   = '0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp", {4'd0, resp_valid, resp_hit, resp_way, resp_evict, resp_evict_tag, resp_error}, 32'd0);
      chk("rst_pol", {18'd0, pol_valid, pol_hit, pol_miss, pol_set_index, pol_access_way}, 32'd0);
      rst_n = 1'b1;

      vecs.push_back(mk(7'd5, 20'h00ABC, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 20'h0, 1'b0));
      vecs.push_back(mk(7'd5, 20'h00ABC, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 20'h0, 1'b0));
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk(7'd7, 20'h100 + 20'(i), 1'b1, 4'(i), 1'b0, 4'(i), 1'b0, 20'h0, 1'b0));
      vecs.push_back(mk(7'd7, 20'h200, 1'b1, 4'd3, 1'b0, 4'd3, 1'b1, 20'h103, 1'b0));
      vecs.push_back(mk(7'd7, 20'h200, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 20'h0, 1'b0));
      vecs.push_back(mk(7'd7, 20'h10A, 1'b0, 4'd0, 1'b1, 4'd10, 1'b0, 20'h0, 1'b0));
      vecs.push_back(mk(7'd9, 20'h00055, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 20'h0, 1'b1));
      vecs.push_back(mk(7'd9, 20'h00055, 1'b1, 4'd1, 1'b0, 4'd1, 1'b0, 20'h0, 1'b0));
      vecs.push_back(mk(7'd9, 20'h00055, 1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 20'h0, 1'b0));
      vecs.push_back(mk(7'd6, 20'h00ABC, 1'b1, 4'd2, 1'b0, 4'd2, 1'b0, 20'h0, 1'b0));
      vecs.push_back(mk(7'd6, 20'h00ABC, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 20'h0, 1'b0));
      vecs.push_back(mk(7'd5, 20'h00ABC, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 20'h0, 1'b0));
      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset while a miss is waiting for a victim that never arrives.
      pol_ways.delete();
      exp_pol_set = 7'd7;
      issue(7'd7, 20'h300, acc);
      @(negedge clk);
      req_valid = 1'b0;
      k = 0;
      while (!pol_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("pol_valid_pre_rst", {31'd0, pol_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("pol_valid_async_rst", {31'd0, pol_valid}, 32'd0);
      chk("req_ready_async_rst", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(mk(7'd5, 20'h00ABC, 1'b1, 4'd4, 1'b0, 4'd4, 1'b0, 20'h0, 1'b0));
      run_vec(mk(7'd7, 20'h200, 1'b1, 4'd3, 1'b0, 4'd3, 1'b0, 20'h0, 1'b0));
      run_vec(mk(7'd7, 20'h10A, 1'b1, 4'd10, 1'b0, 4'd10, 1'b0, 20'h0, 1'b0));

      // Back-to-back misses with req_valid held high.
      pol_ways.delete();
      pol_ways.push_back(4'd5);
      pol_ways.push_back(4'd6);
      exp_pol_set = 7'd12;
      issue(7'd12, 20'h777, acc);
      sb.push_back(mk_exp(mk(7'd12, 20'h777, 1'b1, 4'd5, 1'b0, 4'd5, 1'b0, 20'h0, 1'b0), acc));
      @(negedge clk);
      req_tag = 20'h778;
      chk("hold_ready_lookup", {31'd0, req_ready}, 32'd0);
      seen_hi = 1'b0;
      gap = 0;
      k = 0;
      while (!req_ready && k < 200) begin
         @(negedge clk);
         k++;
         if (pol_valid) seen_hi = 1'b1;
         else if (seen_hi && !pol_miss) gap++;
      end
      chk("hold_ready_again", {31'd0, req_ready}, 32'd1);
      chk("hold_pol_seen", {31'd0, seen_hi}, 32'd1);
      chk("hold_pol_gap", (gap >= 1) ? 32'd1 : 32'd0, 32'd1);
      acc2 = cyc;
      sb.push_back(mk_exp(mk(7'd12, 20'h778, 1'b1, 4'd6, 1'b0, 4'd6, 1'b0, 20'h0, 1'b0), acc2));
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("hold_ready_lookup2", {31'd0, req_ready}, 32'd0);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit expired");
   end
endmodule
`default_nettype wire
